// File: rtl/usr_pkg.sv
// Shared mode encodings for the universal shift register and its frame counter.
package usr_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  // Bits needed to hold a count of 0..frame_len inclusive.
  function automatic int cnt_width(input int frame_len);
    return (frame_len < 1) ? 1 : $clog2(frame_len + 1);
  endfunction

endpackage

// File: rtl/shift_frame_counter.sv
// Counts enabled shifts and flags (combinationally, alongside inc) the shift that completes a frame.
module shift_frame_counter
  import usr_pkg::*;
#(
  parameter int FRAME_LEN = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic wrap
);

  localparam int CNT_W = cnt_width(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    cnt_d = cnt_q;
    wrap  = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      if (cnt_q == LAST) begin
        cnt_d = '0;
        wrap  = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/universal_shift_reg.sv
// Universal shift register: hold / shift right / shift left / parallel load, with a registered
// serial output and a frame counter that pulses frame_done and captures the word every FRAME_LEN shifts.
module universal_shift_reg
  import usr_pkg::*;
#(
  parameter int               WIDTH     = 4,
  parameter int               FRAME_LEN = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             sin_l,
  input  logic             sin_r,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] par_out,
  output logic             sout,
  output logic             frame_done,
  output logic [WIDTH-1:0] frame_word
);

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] frame_word_q, frame_word_d;
  logic             sout_q, sout_d;
  logic             frame_done_q, frame_done_d;
  logic             inc, clr, wrap;

  always_comb begin
    q_d    = q_q;
    sout_d = sout_q;
    inc    = 1'b0;
    clr    = 1'b0;
    if (en) begin
      case (mode)
        MODE_SHR: begin
          q_d    = {sin_r, q_q[WIDTH-1:1]};
          sout_d = q_q[0];
          inc    = 1'b1;
        end
        MODE_SHL: begin
          q_d    = {q_q[WIDTH-2:0], sin_l};
          sout_d = q_q[WIDTH-1];
          inc    = 1'b1;
        end
        MODE_LOAD: begin
          q_d = load_data;
          clr = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // The captured word is the post-shift value, so it appears on the same edge as par_out.
  always_comb begin
    frame_done_d = wrap;
    frame_word_d = wrap ? q_d : frame_word_q;
  end

  shift_frame_counter #(
    .FRAME_LEN (FRAME_LEN)
  ) u_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (inc),
    .clr   (clr),
    .wrap  (wrap)
  );

  // NOTE: only real state is reset here; no memories exist, so every flop takes a defined value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q          <= RESET_VAL;
      sout_q       <= 1'b0;
      frame_done_q <= 1'b0;
      frame_word_q <= '0;
    end else begin
      q_q          <= q_d;
      sout_q       <= sout_d;
      frame_done_q <= frame_done_d;
      frame_word_q <= frame_word_d;
    end
  end

  assign par_out    = q_q;
  assign sout       = sout_q;
  assign frame_done = frame_done_q;
  assign frame_word = frame_word_q;

endmodule
